zap_ifetch_prefetch_queue: RTL

- Instruction supplier that feeds the fetch stage's I-cache input side.
- Generates sequential word-aligned fetch addresses and issues them on a single-outstanding strobe/ack instruction-memory port.
- Buffers returned words, with their abort status, in a small FIFO and presents them as instruction/valid/abort to the fetch stage.
- Flushes and redirects on a pipeline clear; stops fetching after an instruction abort until redirected.

---
 rtl/zap_ifetch_prefetch_queue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/zap_ifetch_prefetch_queue.sv
// Sequential instruction prefetcher: single-outstanding strobe/ack fetch port feeding a show-ahead FIFO.
// Optional starvation counter (o_starve_cnt) is built when ZAP_PREFETCH_PERF_EN is defined.
module zap_ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic [31:0] i_clear_pc,
  input  logic        i_stall,
  output logic        o_mem_stb,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic        i_mem_err,
  input  logic [31:0] i_mem_data,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic [31:0] o_pc
`ifdef ZAP_PREFETCH_PERF_EN
  ,
  output logic [31:0] o_starve_cnt
`endif
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_L  = (AW+2)'(DEPTH);
  localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'd3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HALT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Bus handshake: a request is live while o_mem_stb=1; o_mem_addr is held
  // until the cycle i_mem_ack=1 completes it. Acks with stb=0 are ignored.
  state_t        state, state_next;
  logic          stb, stb_next;
  logic [31:0]   addr, addr_next;
  logic [31:0]   redirect, redirect_next;
  logic [31:0]   clear_addr;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_data  [DEPTH];
  logic          mem_abort [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic          ack, push, pop, credit_ok;
  logic [AW+1:0] credit_sum;

  assign clear_addr = i_clear_pc & ~32'd3;
  assign ack        = stb & i_mem_ack;
  assign o_valid    = (count != '0);
  assign pop        = o_valid & ~i_stall & ~i_clear;

  // The outstanding request already owns a slot; a same-cycle pop frees one only next cycle.
  assign credit_sum = {1'b0, count} + {{(AW+1){1'b0}}, stb};
  assign credit_ok  = credit_sum < DEPTH_L;

  assign o_mem_stb     = stb;
  assign o_mem_addr    = addr;
  assign o_instruction = mem_data[rd_ptr];
  assign o_instr_abort = mem_abort[rd_ptr];
  assign o_pc          = mem_pc[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_FETCH;
      stb      <= 1'b0;
      addr     <= RESET_ADDR;
      redirect <= '0;
    end else begin
      state    <= state_next;
      stb      <= stb_next;
      addr     <= addr_next;
      redirect <= redirect_next;
    end
  end

  always_comb begin
    state_next    = state;
    stb_next      = stb;
    addr_next     = addr;
    redirect_next = redirect;
    push          = 1'b0;
    if (i_clear) begin
      if (stb && !ack) begin
        // Live request must finish on the old address; remember where to go afterwards.
        state_next    = ST_FLUSH;
        redirect_next = clear_addr;
      end else begin
        state_next = ST_FETCH;
        addr_next  = clear_addr;
        stb_next   = 1'b1;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (ack) begin
            push = 1'b1;
            if (i_mem_err) begin
              state_next = ST_HALT;
              stb_next   = 1'b0;
            end else begin
              addr_next = addr + 32'd4;
              stb_next  = credit_ok;
            end
          end else if (!stb) begin
            stb_next = credit_ok;
          end
        end
        ST_HALT: begin
          stb_next = 1'b0;
        end
        ST_FLUSH: begin
          if (ack) begin
            state_next = ST_FETCH;
            addr_next  = redirect;
            stb_next   = 1'b1;
          end
        end
        default: begin
          state_next = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_data[i]  <= '0;
        mem_abort[i] <= 1'b0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]    <= addr;
        mem_data[wr_ptr]  <= i_mem_err ? 32'd0 : i_mem_data;
        mem_abort[wr_ptr] <= i_mem_err;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ZAP_PREFETCH_PERF_EN
  logic [31:0] starve_cnt;

  // Halted cycles are not starvation: the core is waiting on the abort, not on memory.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      starve_cnt <= '0;
    end else if (!o_valid && state != ST_HALT && starve_cnt != 32'hFFFF_FFFF) begin
      starve_cnt <= starve_cnt + 32'd1;
    end
  end

  assign o_starve_cnt = starve_cnt;
`endif

endmodule
